prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Program loader: assembles 20-bit words from a byte stream and writes them to instruction memory.
// Optional trailing XOR checksum byte enabled by macro PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int DEPTH  = 20,
    parameter int WORD_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [19:0]       wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // state | meaning
    // IDLE  | waiting for start
    // B0    | expecting byte carrying word bits [19:16] in its low nibble
    // B1    | expecting byte for word bits [15:8]
    // B2    | expecting byte for word bits [7:0]
    // WRITE | one-cycle memory write of the assembled word
    // CHECK | expecting checksum byte (checksum build only)
    // FIN   | one-cycle done pulse
    typedef enum logic [2:0] {
        IDLE,
        B0,
        B1,
        B2,
        WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
        CHECK,
`endif
        FIN
    } state_t;

    localparam logic [19:0] DEPTH_L = 20'(DEPTH);

    state_t            state_q, state_d;
    logic [19:0]       cnt_q, cnt_d;
    logic [19:0]       cnt_inc;
    logic [3:0]        hi_q, hi_d;
    logic [7:0]        mid_q, mid_d;
    logic [19:0]       addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              err_q, err_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            mid_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            mid_q   <= mid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cnt_inc  = cnt_q + 20'd1;
        hi_d     = hi_q;
        mid_d    = mid_q;
        addr_d   = addr_q;
        data_d   = data_q;
        in_ready = 1'b0;
        wr_en    = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = B0;
                    cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            B0: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hi_d    = in_data[3:0];
                    state_d = B1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ in_data;
`endif
                end
            end
            B1: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mid_d   = in_data;
                    state_d = B2;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ in_data;
`endif
                end
            end
            B2: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // address and data are captured here so they hold after the write
                    addr_d  = cnt_q;
                    data_d  = WORD_W'({hi_q, mid_q, in_data});
                    state_d = WRITE;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ in_data;
`endif
                end
            end
            WRITE: begin
                wr_en = 1'b1;
                cnt_d = cnt_inc;
                if (cnt_inc < DEPTH_L) begin
                    state_d = B0;
                end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = FIN;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    err_d   = (in_data != csum_q);
                    state_d = FIN;
                end
            end
`endif
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_addr = addr_q;
    assign wr_data = data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
